// File: rtl/i2cslave.sv
// I2C target that turns bus transactions into register-file write/read strobes.
// SCL/SDA are synchronized and glitch-filtered; all bus decisions use the filtered levels.
module i2cslave #(
    parameter logic [6:0] ADDR   = 7'h50,
    parameter int         FILTER = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sdarx,
    output logic       sdaoe,
    output logic [7:0] regaddr,
    output logic [7:0] wdata,
    output logic       wstb,
    output logic       rstb,
    input  logic [7:0] rdata,
    output logic       busy
);
    localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDRACK, S_PTR, S_WDATA, S_WACK, S_RDATA, S_RDACK
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       pin_p0, pin_p1, flt, flt_q;   // bit 0 = SCL, bit 1 = SDA
    logic [CNT_W-1:0] flt_cnt [2];
    logic             scl_rise, scl_fall, start_det, stop_det, byte_done, tx_shift;
    logic [2:0]       bitcnt;
    logic             ninth, rw, rd_vld_p1;
    logic [7:0]       shreg, rx_byte;

    // stage p0/p1: two-flop synchronizer; then FILTER-deep agreement filter
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_p0 <= 2'b11;
            pin_p1 <= 2'b11;
            flt    <= 2'b11;
            flt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            pin_p0 <= {sdarx, scl};
            pin_p1 <= pin_p0;
            flt_q  <= flt;
            for (int i = 0; i < 2; i++) begin
                if (pin_p1[i] == flt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CNT_W'(FILTER - 1)) begin
                    flt[i]     <= pin_p1[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_rise  = flt[0] & ~flt_q[0];
    assign scl_fall  = ~flt[0] & flt_q[0];
    assign start_det = flt[0] & flt_q[0] & flt_q[1] & ~flt[1];
    assign stop_det  = flt[0] & flt_q[0] & ~flt_q[1] & flt[1];
    assign byte_done = scl_rise && (bitcnt == 3'd7);
    assign rx_byte   = {shreg[6:0], flt[1]};
    assign tx_shift  = scl_fall && ((state == S_ADDRACK && ninth && rw) ||
                                    (state == S_RDATA && bitcnt != 3'd0) ||
                                    (state == S_RDACK));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = S_ADDR;
        end else if (stop_det) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_ADDR:    if (byte_done) state_nxt = (shreg[6:0] == ADDR) ? S_ADDRACK : S_IDLE;
                S_ADDRACK: if (scl_fall && ninth) state_nxt = rw ? S_RDATA : S_PTR;
                S_PTR:     if (byte_done) state_nxt = S_WACK;
                S_WDATA:   if (byte_done) state_nxt = S_WACK;
                S_WACK:    if (scl_fall && ninth) state_nxt = S_WDATA;
                S_RDATA:   if (scl_fall && bitcnt == 3'd0) state_nxt = S_RDACK;
                S_RDACK: begin
                    if (scl_rise && flt[1]) state_nxt = S_IDLE;
                    else if (scl_fall)      state_nxt = S_RDATA;
                end
                default:   state_nxt = state;
            endcase
        end
    end

    // stage p1: read data returns two cycles after rstb
    always_ff @(posedge clk) begin
        if (rd_vld_p1)
            shreg <= rdata;
        else if (scl_rise && (state inside {S_ADDR, S_PTR, S_WDATA}))
            shreg <= rx_byte;
        else if (tx_shift)
            shreg <= {shreg[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdaoe     <= 1'b0;
            regaddr   <= 8'd0;
            wdata     <= 8'd0;
            wstb      <= 1'b0;
            rstb      <= 1'b0;
            busy      <= 1'b0;
            bitcnt    <= 3'd0;
            ninth     <= 1'b0;
            rw        <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            wstb      <= 1'b0;
            rstb      <= 1'b0;
            rd_vld_p1 <= rstb;
            if (wstb) regaddr <= regaddr + 8'd1;
            if (start_det || stop_det) begin
                bitcnt <= 3'd0;
                ninth  <= 1'b0;
                sdaoe  <= 1'b0;
                if (stop_det) busy <= 1'b0;
            end else begin
                if (scl_rise && (state inside {S_ADDR, S_PTR, S_WDATA, S_RDATA}))
                    bitcnt <= bitcnt + 3'd1;
                case (state)
                    S_ADDR: if (byte_done) begin
                        rw   <= flt[1];
                        busy <= (shreg[6:0] == ADDR);
                    end
                    S_PTR:   if (byte_done) regaddr <= rx_byte;
                    S_WDATA: if (byte_done) begin
                        wdata <= rx_byte;
                        wstb  <= 1'b1;
                    end
                    // first fall drives ACK, second fall ends it (and starts read data)
                    S_ADDRACK, S_WACK: if (scl_fall) begin
                        if (!ninth) begin
                            ninth <= 1'b1;
                            sdaoe <= 1'b1;
                            if (state == S_ADDRACK && rw) rstb <= 1'b1;
                        end else begin
                            ninth <= 1'b0;
                            sdaoe <= (state == S_ADDRACK && rw) ? ~shreg[7] : 1'b0;
                        end
                    end
                    S_RDATA: if (scl_fall) sdaoe <= (bitcnt == 3'd0) ? 1'b0 : ~shreg[7];
                    S_RDACK: begin
                        if (scl_rise) begin
                            if (flt[1]) begin
                                busy <= 1'b0;
                            end else begin
                                regaddr <= regaddr + 8'd1;
                                rstb    <= 1'b1;
                            end
                        end
                        if (scl_fall) sdaoe <= ~shreg[7];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2cslave.sv
// Bench for i2cslave: bit-banged I2C master, registered register-file model,
// and queues of expected write strobes and read bytes.
module tb_i2cslave;
    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic       sdaoe, wstb, rstb, busy, sda_line;
    logic [7:0] regaddr, wdata, rdata;

    int   n_chk = 0, n_err = 0;
    int   wstb_cnt = 0, rstb_cnt = 0;
    logic oe_seen = 1'b0, busy_seen = 1'b0;
    logic [15:0] wq [$];
    logic [7:0]  rq [$];

    assign sda_line = sda_m & ~sdaoe;

    always #5 clk = ~clk;

    i2cslave #(.ADDR(7'h50), .FILTER(3)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sdarx(sda_line), .sdaoe(sdaoe),
        .regaddr(regaddr), .wdata(wdata), .wstb(wstb), .rstb(rstb),
        .rdata(rdata), .busy(busy)
    );

    // registered register file: contents are the bitwise inverse of the address
    always @(posedge clk) rdata <= ~regaddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wstb) begin
            wstb_cnt++;
            check("wstb_pending", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) check("wstb_addr_data", {16'd0, regaddr, wdata}, {16'd0, wq.pop_front()});
        end
        if (rstb)  rstb_cnt++;
        if (sdaoe) oe_seen = 1'b1;
        if (busy)  busy_seen = 1'b1;
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl = 1'b1;   qwait();
        sda_m = 1'b0; qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl = 1'b1;   qwait();
        sda_m = 1'b1; qwait(); qwait();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b;
        if (glitch) begin
            repeat (4) @(negedge clk);
            scl = 1'b1;
            repeat (2) @(negedge clk);
            scl = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            qwait();
        end
        scl = 1'b1; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic clock_bit(output logic b);
        qwait();
        scl = 1'b1; qwait();
        b = sda_line; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
        sda_m = 1'b1;
        clock_bit(ack);
    endtask

    task automatic wr(input string tag, input logic [7:0] d, input int gbit, input logic exp_ack);
        logic ack;
        write_byte(d, gbit, ack);
        check(tag, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic rd(input logic nack);
        logic [7:0] d;
        logic dummy;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1;
            clock_bit(d[i]);
        end
        sda_m = nack;
        clock_bit(dummy);
        sda_m = 1'b1;
        check("rd_pending", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) check("rd_byte", {24'd0, d}, {24'd0, rq.pop_front()});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sdaoe"},   {31'd0, sdaoe}, 32'd0);
        check({tag, "_regaddr"}, {24'd0, regaddr}, 32'd0);
        check({tag, "_wdata"},   {24'd0, wdata}, 32'd0);
        check({tag, "_wstb"},    {31'd0, wstb}, 32'd0);
        check({tag, "_rstb"},    {31'd0, rstb}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0;
        repeat (5) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // write with auto-increment
        bus_start();
        wr("ack_addr_w", 8'hA0, -1, 1'b0);
        check("busy_after_match", {31'd0, busy}, 32'd1);
        wr("ack_ptr", 8'h10, -1, 1'b0);
        wq.push_back({8'h10, 8'hA5});
        wr("ack_d0", 8'hA5, -1, 1'b0);
        wq.push_back({8'h11, 8'h5A});
        wr("ack_d1", 8'h5A, -1, 1'b0);
        bus_stop();
        check("wr_final_regaddr", {24'd0, regaddr}, 32'h12);
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check("wr_wstb_count", wstb_cnt, 32'd2);

        // pointer write, repeated START, read two bytes
        r0 = rstb_cnt;
        bus_start();
        wr("ack_addr_w2", 8'hA0, -1, 1'b0);
        wr("ack_ptr2", 8'h20, -1, 1'b0);
        bus_start();
        wr("ack_addr_r", 8'hA1, -1, 1'b0);
        rq.push_back(8'hDF);
        rq.push_back(8'hDE);
        rd(1'b0);
        rd(1'b1);
        check("rd_sda_released", {31'd0, sdaoe}, 32'd0);
        bus_stop();
        check("rd_rstb_count", rstb_cnt - r0, 32'd2);
        check("rd_busy_after", {31'd0, busy}, 32'd0);
        check("rd_final_regaddr", {24'd0, regaddr}, 32'h21);

        // wrong address
        repeat (20) @(negedge clk);
        oe_seen = 1'b0; busy_seen = 1'b0;
        w0 = wstb_cnt; r0 = rstb_cnt;
        bus_start();
        wr("nack_wrong_addr", 8'hA2, -1, 1'b1);
        wr("nack_wrong_data", 8'h33, -1, 1'b1);
        bus_stop();
        check("wrong_oe_seen", {31'd0, oe_seen}, 32'd0);
        check("wrong_busy_seen", {31'd0, busy_seen}, 32'd0);
        check("wrong_wstb", wstb_cnt - w0, 32'd0);
        check("wrong_rstb", rstb_cnt - r0, 32'd0);

        // short SCL glitch inside a data byte
        bus_start();
        wr("ack_addr_g", 8'hA0, -1, 1'b0);
        wr("ack_ptr_g", 8'h50, -1, 1'b0);
        wq.push_back({8'h50, 8'h3C});
        wr("ack_data_g", 8'h3C, 3, 1'b0);
        bus_stop();
        check("glitch_regaddr", {24'd0, regaddr}, 32'h51);

        // STOP after four data bits
        w0 = wstb_cnt;
        bus_start();
        wr("ack_addr_s", 8'hA0, -1, 1'b0);
        wr("ack_ptr_s", 8'h60, -1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        bus_stop();
        check("partial_no_wstb", wstb_cnt - w0, 32'd0);
        check("partial_regaddr", {24'd0, regaddr}, 32'h60);
        check("partial_busy", {31'd0, busy}, 32'd0);

        // pointer wrap
        bus_start();
        wr("ack_addr_p", 8'hA0, -1, 1'b0);
        wr("ack_ptr_p", 8'hFF, -1, 1'b0);
        wq.push_back({8'hFF, 8'h11});
        wr("ack_wrap0", 8'h11, -1, 1'b0);
        wq.push_back({8'h00, 8'h22});
        wr("ack_wrap1", 8'h22, -1, 1'b0);
        bus_stop();
        check("wrap_regaddr", {24'd0, regaddr}, 32'h01);

        // reset while the target is pulling SDA low
        bus_start();
        wr("ack_addr_x", 8'hA0, -1, 1'b0);
        wr("ack_ptr_x", 8'h40, -1, 1'b0);
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(r0[0] | 1'b1 ? 8'hA1 >> i : 1'b0, 1'b0);
        sda_m = 1'b1;
        for (int k = 0; k < 40 && !sdaoe; k++) @(negedge clk);
        check("rst_oe_driven", {31'd0, sdaoe}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        qwait();
        scl = 1'b1;
        qwait(); qwait();
        bus_start();
        wr("ack_addr_after", 8'hA0, -1, 1'b0);
        wr("ack_ptr_after", 8'h30, -1, 1'b0);
        wq.push_back({8'h30, 8'h77});
        wr("ack_data_after", 8'h77, -1, 1'b0);
        bus_stop();
        check("after_rst_regaddr", {24'd0, regaddr}, 32'h31);

        repeat (20) @(negedge clk);
        check("wq_drained", wq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/i2cslave.md
# i2cslave

I2C target (responder) that maps bus transactions onto an 8-bit register-file strobe interface. It is the far end of the protocol driven by `i2cmaster`. It lets an on-board controller, or the board's own `i2cmaster` looped through the `iic` mux, read and write gateware configuration registers over SDA/SCL. It sits on `clk100` beside the config logic, and SDA is driven open-drain through a top-level IOBUF.

## Interface
- `ADDR`, 7'h50, 7-bit bus address this target answers to.
- `FILTER`, 3, number of consecutive identical synchronized samples required before SCL/SDA change state.
- `clk` in 1: system clock; must be at least 20× the SCL rate.
- `rst` in 1: reset, synchronous, active-high.
- `scl` in 1: SCL pin (input only; no clock stretching).
- `sdarx` in 1: SDA pin input.
- `sdaoe` out 1: 1 pulls SDA low. Top level uses IOBUF I=0, T=~sdaoe.
- `regaddr` out 8: register pointer.
- `wdata` out 8: write data, valid while `wstb` is high.
- `wstb` out 1: one-cycle write strobe.
- `rstb` out 1: one-cycle read request for `regaddr`.
- `rdata` in 8: read data, sampled 2 cycles after `rstb`.
- `busy` out 1: high from an address match until STOP or NACK.

## Operation
- **Input conditioning**
  - `scl`/`sdarx` each pass through a 2-flop synchronizer and then a FILTER-deep glitch filter.
  - Edge and START/STOP detection use only the filtered values.
- **Bus conditions**
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - Both are honored in every state.
- **Bit timing**
  - Bits are MSB first and sampled on the SCL rising edge.
  - `sdaoe` changes only on an SCL falling edge, or on STOP/reset.
- **States**
  - IDLE → ADDR on START. A bit counter (3 bits, plus a ninth-bit flag) is cleared on each START.
  - ADDR, after 8 bits:
    - Address ≠ ADDR: go to IDLE, `sdaoe` stays 0.
    - Match: go to ADDRACK, `busy`=1, and drive `sdaoe`=1 from the next SCL fall to the following SCL fall.
  - ADDRACK exit:
    - R/W=0 → PTR.
    - R/W=1 → RDATA.
  - PTR: the 8 bits received load `regaddr`; ACK as above; → WDATA.
  - WDATA: on the 8th rising edge, load `wdata` and pulse `wstb` the next cycle. `regaddr` increments the cycle after `wstb`, mod 256 (0xFF → 0x00). ACK; stay in WDATA.
  - RDATA:
    - `rstb` pulses the cycle after the SCL fall that begins ADDRACK (first byte), or the cycle after master-ACK sampling (later bytes).
    - `rdata` is captured into the shift register 2 cycles after `rstb`.
    - Drive `sdaoe`=~bit on each SCL fall, for 8 bits.
    - Release SDA for the 9th bit and sample master ACK on its rising edge:
      - ACK (SDA low): increment `regaddr`, pulse `rstb`, and continue.
      - NACK: go to IDLE.
- **Repeated START** in any state: go to ADDR and release SDA. `regaddr` is retained, which allows pointer-write-then-read.
- **STOP** in any state: go to IDLE, `sdaoe`=0, `busy`=0. A partial byte is discarded with no `wstb`.
- **Simultaneous events:** STOP/START detection has priority over bit processing in the same cycle.

## Timing
- **Reset values:** `sdaoe`=0, `regaddr`=0, `wdata`=0, `wstb`=0, `rstb`=0, `busy`=0, state IDLE.
- **Reset mid-transaction:** all outputs return to reset values on the cycle after `rst` is sampled high. SDA is released immediately.
- **Detection latency:** pin change → filtered edge or START/STOP = 2+FILTER cycles.
- **SDA output latency:** `sdaoe` update = 1 cycle after the filtered SCL falling edge.
- **Glitch rejection:** pulses shorter than FILTER cycles on either pin produce no edge.
- **Write strobe:** `wstb` fires 1 cycle after the filtered 8th rising edge. `wdata`/`regaddr` are stable during `wstb`.
- **Read path:** `rstb` → `rdata` capture takes 2 cycles, which allows a registered register-file read. Capture always completes before the next SCL fall, given clk ≥ 20×SCL.

## Test plan
- **Write with auto-increment:** START, 0xA0, pointer 0x10, data 0xA5, 0x5A, STOP → ACK low on all four 9th bits; `wstb` twice with (`regaddr`,`wdata`) = (0x10,0xA5) then (0x11,0x5A); final `regaddr`=0x12; `busy` low after STOP.
- **Pointer write, repeated START, read two bytes:**
  - Stimulus: START, 0xA0, 0x20, Sr, 0xA1, read two bytes (master ACK then NACK), STOP. Model `rdata`=~`regaddr`, delayed 1 cycle.
  - Response: bytes 0xDF then 0xDE on SDA; `rstb` exactly twice; SDA released after NACK.
- **Wrong address:** 0xA2 → no ACK; `sdaoe`=0, no `wstb`/`rstb`, `busy`=0 throughout.
- **Glitch:** 2-cycle pulse on SCL during a data bit (FILTER=3) → no extra bit counted; data received correctly.
- **STOP mid-byte:** STOP after 4 data bits → IDLE, no `wstb`. **Pointer wrap:** pointer 0xFF with two data bytes → writes to 0xFF then 0x00.
- **Reset mid-read:** assert `rst` while `sdaoe`=1 → `sdaoe`=0 next cycle, all outputs at reset values; the next transaction succeeds.
